// File: rtl/sd_pkg.sv
// Shared constants and types for the SD sector reader: SPI command codes,
// CMD17 framing, data token, result codes and sector geometry.
package sd_pkg;

  typedef enum logic [1:0] {
    SpiInit   = 2'd0,
    SpiXfer   = 2'd1,
    SpiCsLow  = 2'd2,
    SpiCsHigh = 2'd3
  } spi_cmd_e;

  typedef enum logic [2:0] {
    ErrNone       = 3'd0,
    ErrSpiTimeout = 3'd1,
    ErrR1Timeout  = 3'd2,
    ErrR1Bad      = 3'd3,
    ErrTokTimeout = 3'd4,
    ErrTokBad     = 3'd5
  } sd_err_e;

  localparam logic [7:0]  Cmd17       = 8'h51;
  localparam logic [7:0]  TokenStart  = 8'hFE;
  localparam logic [7:0]  IdleByte    = 8'hFF;
  localparam int unsigned SectorBytes = 512;

  // Byte idx of the six-byte CMD17 frame; the trailing CRC byte is a dummy 0xFF.
  function automatic logic [7:0] cmd_byte(input logic [31:0] lba, input logic [2:0] idx);
    case (idx)
      3'd0:    return Cmd17;
      3'd1:    return lba[31:24];
      3'd2:    return lba[23:16];
      3'd3:    return lba[15:8];
      3'd4:    return lba[7:0];
      default: return IdleByte;
    endcase
  endfunction

endpackage

// File: rtl/sd_spi_op.sv
// Single SPI operation: forwards the registered request strobe to the sdcard
// controller and waits for it to finish, reporting the received byte.
module sd_spi_op
  import sd_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  spi_cmd_e   cmd,
  input  logic [7:0] tx,
  output logic       spi_sent,
  output logic [1:0] spi_cmd,
  output logic [7:0] spi_out,
  input  logic [7:0] spi_din,
  input  logic [1:0] spi_st,
  output logic       op_done,
  output logic       op_timeout,
  output logic [7:0] op_rx
);

  typedef enum logic [1:0] {OpIdle, OpSkip, OpWait} op_state_e;

  op_state_e state;

  // Request fields come straight from the caller's flops, so the strobe is registered.
  assign spi_sent = go;
  assign spi_cmd  = cmd;
  assign spi_out  = tx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= OpIdle;
      op_done    <= 1'b0;
      op_timeout <= 1'b0;
      op_rx      <= 8'h00;
    end else begin
      op_done <= 1'b0;
      unique case (state)
        OpIdle: if (go) state <= OpSkip;
        // The controller's busy flag is not yet valid in the cycle after the strobe.
        OpSkip: state <= OpWait;
        OpWait: begin
          if (!spi_st[1]) begin
            op_done    <= 1'b1;
            op_timeout <= spi_st[0];
            op_rx      <= spi_din;
            state      <= OpIdle;
          end
        end
        default: state <= OpIdle;
      endcase
    end
  end

endmodule

// File: rtl/sd_sector_reader.sv
// Reads one 512-byte sector via CMD17 over the sdcard SPI controller and writes
// it into RAM through a request/grant write port, without CPU involvement.
module sd_sector_reader
  import sd_pkg::*;
#(
  parameter int unsigned R1_TRIES    = 8,
  parameter int unsigned TOKEN_TRIES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] lba,
  input  logic [15:0] base,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  output logic        spi_sent,
  output logic [1:0]  spi_cmd,
  output logic [7:0]  spi_out,
  input  logic [7:0]  spi_din,
  input  logic [1:0]  spi_st,
  output logic        mem_req,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_d,
  input  logic        mem_gnt
);

  localparam int unsigned MaxTries = (R1_TRIES > TOKEN_TRIES) ? R1_TRIES : TOKEN_TRIES;
  localparam int unsigned TryW     = $clog2(MaxTries + 1);
  localparam logic [TryW-1:0] R1Max  = TryW'(R1_TRIES);
  localparam logic [TryW-1:0] TokMax = TryW'(TOKEN_TRIES);
  localparam logic [TryW-1:0] TryOne = TryW'(1);

  typedef enum logic [3:0] {
    StIdle, StSel, StCmd, StR1, StTok, StData, StWr, StCrc, StDesel, StTrail, StFin
  } state_e;

  state_e          state;
  logic [31:0]     lba_r;
  logic [15:0]     base_r;
  logic [9:0]      idx;
  logic [2:0]      cnt;
  logic [TryW-1:0] tries;
  logic            op_go;
  spi_cmd_e        op_cmd;
  logic [7:0]      op_tx;
  logic            op_done;
  logic            op_timeout;
  logic [7:0]      op_rx;

  sd_spi_op u_op (
    .clock      (clock),
    .reset_n    (reset_n),
    .go         (op_go),
    .cmd        (op_cmd),
    .tx         (op_tx),
    .spi_sent   (spi_sent),
    .spi_cmd    (spi_cmd),
    .spi_out    (spi_out),
    .spi_din    (spi_din),
    .spi_st     (spi_st),
    .op_done    (op_done),
    .op_timeout (op_timeout),
    .op_rx      (op_rx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 3'd0;
      lba_r   <= 32'd0;
      base_r  <= 16'd0;
      idx     <= 10'd0;
      cnt     <= 3'd0;
      tries   <= '0;
      op_go   <= 1'b0;
      op_cmd  <= SpiInit;
      op_tx   <= 8'h00;
      mem_req <= 1'b0;
      mem_a   <= 16'd0;
      mem_d   <= 8'h00;
    end else begin
      op_go <= 1'b0;
      done  <= 1'b0;
      // Timeouts during deselect are ignored so the first error code survives.
      if (op_done && op_timeout && state != StDesel && state != StTrail) begin
        err    <= ErrSpiTimeout;
        state  <= StDesel;
        op_go  <= 1'b1;
        op_cmd <= SpiCsHigh;
        op_tx  <= IdleByte;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              lba_r  <= lba;
              base_r <= base;
              busy   <= 1'b1;
              err    <= ErrNone;
              idx    <= 10'd0;
              op_go  <= 1'b1;
              op_cmd <= SpiCsLow;
              op_tx  <= IdleByte;
              state  <= StSel;
            end
          end
          StSel: begin
            if (op_done) begin
              cnt    <= 3'd0;
              op_go  <= 1'b1;
              op_cmd <= SpiXfer;
              op_tx  <= cmd_byte(lba_r, 3'd0);
              state  <= StCmd;
            end
          end
          StCmd: begin
            if (op_done) begin
              op_go  <= 1'b1;
              op_cmd <= SpiXfer;
              if (cnt == 3'd5) begin
                tries <= TryOne;
                op_tx <= IdleByte;
                state <= StR1;
              end else begin
                cnt   <= cnt + 3'd1;
                op_tx <= cmd_byte(lba_r, cnt + 3'd1);
              end
            end
          end
          StR1: begin
            if (op_done) begin
              op_go  <= 1'b1;
              op_tx  <= IdleByte;
              op_cmd <= SpiXfer;
              if (op_rx == 8'h00) begin
                tries <= TryOne;
                state <= StTok;
              end else if (op_rx != IdleByte || tries == R1Max) begin
                err    <= (op_rx != IdleByte) ? ErrR1Bad : ErrR1Timeout;
                op_cmd <= SpiCsHigh;
                state  <= StDesel;
              end else begin
                tries <= tries + TryOne;
              end
            end
          end
          StTok: begin
            if (op_done) begin
              op_go  <= 1'b1;
              op_tx  <= IdleByte;
              op_cmd <= SpiXfer;
              if (op_rx == TokenStart) begin
                state <= StData;
              end else if (op_rx[7:4] == 4'h0 || tries == TokMax) begin
                err    <= (op_rx[7:4] == 4'h0) ? ErrTokBad : ErrTokTimeout;
                op_cmd <= SpiCsHigh;
                state  <= StDesel;
              end else begin
                tries <= tries + TryOne;
              end
            end
          end
          StData: begin
            if (op_done) begin
              mem_req <= 1'b1;
              mem_a   <= base_r + {7'd0, idx[8:0]};
              mem_d   <= op_rx;
              state   <= StWr;
            end
          end
          StWr: begin
            if (mem_gnt) begin
              mem_req <= 1'b0;
              idx     <= idx + 10'd1;
              op_go   <= 1'b1;
              op_cmd  <= SpiXfer;
              op_tx   <= IdleByte;
              cnt     <= 3'd0;
              state   <= (idx == 10'(SectorBytes - 1)) ? StCrc : StData;
            end
          end
          StCrc: begin
            if (op_done) begin
              op_go  <= 1'b1;
              op_tx  <= IdleByte;
              op_cmd <= (cnt == 3'd1) ? SpiCsHigh : SpiXfer;
              cnt    <= 3'd1;
              if (cnt == 3'd1) state <= StDesel;
            end
          end
          StDesel: begin
            if (op_done) begin
              op_go  <= 1'b1;
              op_cmd <= SpiXfer;
              op_tx  <= IdleByte;
              state  <= StTrail;
            end
          end
          StTrail: begin
            if (op_done) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= StFin;
            end
          end
          StFin:   state <= StIdle;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: a byte-level SD card and RAM model drive the DUT
// through success, error, stall, wrap, timeout and reset scenarios.
module tb_sd_sector_reader;

  localparam int Lat = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] lba = 32'd0;
  logic [15:0] base = 16'd0;
  logic        busy, done, spi_sent, mem_req;
  logic [2:0]  err;
  logic [1:0]  spi_cmd;
  logic [7:0]  spi_out, mem_d;
  logic [15:0] mem_a;
  logic [7:0]  spi_din = 8'hFF;
  logic [1:0]  spi_st = 2'b00;
  logic        mem_gnt = 1'b1;

  int total = 0;
  int bad = 0;

  // Card model state
  int          ph = 0, cphase = 0, nbytes = 0, op_n = 0, tmo_at = 0;
  int          r1_at = 0, tok_at = 0, r1_polls = 0, tok_polls = 0, di = 0;
  int          cs_high_n = 0, trail_n = 0, after_tmo_cmd = -1;
  bit          tmo = 1'b0, tmo_seen = 1'b0;
  logic [7:0]  r1_val = 8'h00, tok_val = 8'hFE, resp = 8'hFF;
  logic [7:0]  cmd_log [6];

  // RAM / write model state
  logic [7:0]  ram [65536];
  int          widx = 0, stall_left = 0, stall_seen = 0;
  bit          stall_en = 1'b0;
  logic [15:0] run_base = 16'd0;
  bit          prev_stall = 1'b0, prev_done = 1'b0;
  logic [15:0] prev_a = 16'd0;
  logic [7:0]  prev_d = 8'd0;

  sd_sector_reader dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .lba      (lba),
    .base     (base),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .spi_sent (spi_sent),
    .spi_cmd  (spi_cmd),
    .spi_out  (spi_out),
    .spi_din  (spi_din),
    .spi_st   (spi_st),
    .mem_req  (mem_req),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_gnt  (mem_gnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SD card behind the sdcard controller: busy rises two cycles after the strobe.
  always begin
    @(posedge clock);
    #1;
    if (!reset_n) begin
      ph = 0;
      spi_st = 2'b00;
    end else if (spi_sent) begin
      check("one_op_in_flight", 32'(ph), 32'd0);
      op_n++;
      if (tmo_seen && after_tmo_cmd < 0) after_tmo_cmd = int'(spi_cmd);
      tmo = (op_n == tmo_at);
      if (tmo) tmo_seen = 1'b1;
      resp = 8'hFF;
      case (spi_cmd)
        2'd2: begin cphase = 1; nbytes = 0; end
        2'd3: begin cphase = 0; cs_high_n++; end
        2'd1: begin
          if (cphase >= 2) check("poll_tx_ff", 32'(spi_out), 32'hFF);
          case (cphase)
            0: trail_n++;
            1: begin
              cmd_log[nbytes] = spi_out;
              nbytes++;
              if (nbytes == 6) cphase = 2;
            end
            2: begin
              r1_polls++;
              if (r1_polls == r1_at) begin
                resp = r1_val;
                cphase = (r1_val == 8'h00) ? 3 : 6;
              end
            end
            3: begin
              tok_polls++;
              if (tok_polls == tok_at) begin
                resp = tok_val;
                cphase = (tok_val == 8'hFE) ? 4 : 6;
              end
            end
            4: begin
              resp = di[7:0];
              di++;
              if (di == 512) cphase = 5;
            end
            default: resp = 8'hA5;
          endcase
        end
        default: ;
      endcase
      ph = 1;
    end else if (ph != 0) begin
      ph++;
      if (ph == 3) spi_st = 2'b10;
      else if (ph == 3 + Lat) begin
        spi_st = {1'b0, tmo};
        spi_din = resp;
        ph = 0;
      end
    end
  end

  // Grant: withheld for 10 cycles on write 7 when stalling is enabled.
  always begin
    @(posedge clock);
    #1;
    if (stall_en && mem_req && widx == 7 && stall_left > 0) begin
      mem_gnt = 1'b0;
      stall_left--;
    end else begin
      mem_gnt = 1'b1;
    end
  end

  // Compare process: write stream, stall stability, bus exclusivity, done/busy.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_req_held", 32'(mem_req), 32'd1);
        check("stall_a_stable", 32'(mem_a), 32'(prev_a));
        check("stall_d_stable", 32'(mem_d), 32'(prev_d));
      end
      if (mem_req) begin
        check("req_no_strobe", 32'(spi_sent), 32'd0);
        check("req_no_op_inflight", 32'(ph), 32'd0);
        if (!mem_gnt) stall_seen++;
      end
      if (mem_req && mem_gnt) begin
        check("wr_addr", 32'(mem_a), 32'(16'(run_base + 16'(widx))));
        check("wr_data", 32'(mem_d), 32'(widx % 256));
        ram[mem_a] = mem_d;
        widx++;
      end
      if (done) begin
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(prev_done), 32'd0);
      end
      prev_stall = mem_req && !mem_gnt;
      prev_a = mem_a;
      prev_d = mem_d;
      prev_done = done;
    end
  end

  task automatic setup(input int r1a, input logic [7:0] r1v, input int toka,
                       input logic [7:0] tokv, input int tmoa, input bit stall);
    r1_at = r1a; r1_val = r1v; tok_at = toka; tok_val = tokv; tmo_at = tmoa;
    r1_polls = 0; tok_polls = 0; op_n = 0; di = 0; nbytes = 0; cphase = 0;
    cs_high_n = 0; trail_n = 0; tmo_seen = 1'b0; after_tmo_cmd = -1;
    for (int k = 0; k < 6; k++) cmd_log[k] = 8'h00;
    widx = 0; stall_en = stall; stall_left = 10; stall_seen = 0;
  endtask

  task automatic start_read(input logic [15:0] b, input logic [31:0] l);
    @(negedge clock);
    run_base = b;
    lba = l;
    base = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("first_strobe_cs_low", 32'({busy, spi_sent, spi_cmd}), 32'b1110);
  endtask

  task automatic wait_done(output logic [2:0] got);
    bit fin = 1'b0;
    got = 3'd7;
    for (int n = 0; n < 40000 && !fin; n++) begin
      if (done) begin
        fin = 1'b1;
        got = err;
      end else begin
        @(negedge clock);
      end
    end
    if (!fin) check("done_within_budget", 32'd0, 32'd1);
  endtask

  task automatic expect_end(input string name, input logic [2:0] got, input logic [2:0] exp_err,
                            input int exp_writes);
    check({name, "_err"}, 32'(got), 32'(exp_err));
    check({name, "_cs_high"}, 32'(cs_high_n), 32'd1);
    check({name, "_trail"}, 32'(trail_n), 32'd1);
    check({name, "_writes"}, 32'(widx), 32'(exp_writes));
  endtask

  initial begin
    logic [2:0] got;
    for (int k = 0; k < 65536; k++) ram[k] = 8'h5A;

    #12;
    check("reset_ctrl", 32'({busy, done, err, spi_sent, spi_cmd, mem_req}), 32'd0);
    check("reset_data", {spi_out, mem_a, mem_d}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Nominal read; also a start coinciding with done must be ignored.
    setup(2, 8'h00, 5, 8'hFE, 0, 1'b0);
    start_read(16'h8000, 32'h0000_0123);
    wait_done(got);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_on_done_ignored", 32'({busy, spi_sent}), 32'd0);
    check("err_held", 32'(err), 32'd0);
    expect_end("ok", got, 3'd0, 512);
    check("cmd0", 32'(cmd_log[0]), 32'h51);
    check("cmd1", 32'(cmd_log[1]), 32'h00);
    check("cmd2", 32'(cmd_log[2]), 32'h00);
    check("cmd3", 32'(cmd_log[3]), 32'h01);
    check("cmd4", 32'(cmd_log[4]), 32'h23);
    check("cmd5", 32'(cmd_log[5]), 32'hFF);
    check("r1_polls", 32'(r1_polls), 32'd2);
    check("tok_polls", 32'(tok_polls), 32'd5);
    check("ram_8000", 32'(ram[16'h8000]), 32'h00);
    check("ram_80ff", 32'(ram[16'h80FF]), 32'hFF);
    check("ram_8100", 32'(ram[16'h8100]), 32'h00);
    check("ram_81ff", 32'(ram[16'h81FF]), 32'hFF);
    check("ram_8200_untouched", 32'(ram[16'h8200]), 32'h5A);

    // R1 never arrives.
    setup(0, 8'h00, 0, 8'hFE, 0, 1'b0);
    start_read(16'h2000, 32'h0000_0001);
    wait_done(got);
    expect_end("r1_timeout", got, 3'd2, 0);
    check("r1_timeout_polls", 32'(r1_polls), 32'd8);

    // R1 reports an error bit.
    setup(1, 8'h04, 0, 8'hFE, 0, 1'b0);
    start_read(16'h2000, 32'h0000_0002);
    wait_done(got);
    expect_end("r1_bad", got, 3'd3, 0);
    check("r1_bad_polls", 32'(r1_polls), 32'd1);

    // Data error token.
    setup(1, 8'h00, 3, 8'h05, 0, 1'b0);
    start_read(16'h2000, 32'h0000_0003);
    wait_done(got);
    expect_end("tok_bad", got, 3'd5, 0);
    check("tok_bad_polls", 32'(tok_polls), 32'd3);

    // Token never arrives.
    setup(1, 8'h00, 0, 8'hFE, 0, 1'b0);
    start_read(16'h2000, 32'h0000_0004);
    wait_done(got);
    expect_end("tok_timeout", got, 3'd4, 0);
    check("tok_timeout_polls", 32'(tok_polls), 32'd4096);

    // Grant withheld on byte 7, destination wraps past 0xFFFF.
    setup(1, 8'h00, 1, 8'hFE, 0, 1'b1);
    start_read(16'hFF00, 32'hDEAD_BEEF);
    wait_done(got);
    expect_end("wrap", got, 3'd0, 512);
    check("wrap_stall_cycles", 32'(stall_seen), 32'd10);
    check("wrap_cmd1", 32'(cmd_log[1]), 32'hDE);
    check("wrap_cmd4", 32'(cmd_log[4]), 32'hEF);
    check("ram_ff00", 32'(ram[16'hFF00]), 32'h00);
    check("ram_ff07", 32'(ram[16'hFF07]), 32'h07);
    check("ram_ffff", 32'(ram[16'hFFFF]), 32'hFF);
    check("ram_0000", 32'(ram[16'h0000]), 32'h00);
    check("ram_00ff", 32'(ram[16'h00FF]), 32'hFF);

    // SPI timeout on the third command byte.
    setup(1, 8'h00, 1, 8'hFE, 4, 1'b0);
    start_read(16'h2000, 32'h0000_0005);
    wait_done(got);
    expect_end("spi_tmo", got, 3'd1, 0);
    check("spi_tmo_cmd_bytes", 32'(nbytes), 32'd3);
    check("spi_tmo_next_cs_high", 32'(after_tmo_cmd), 32'd3);

    // Reset in the middle of the data phase, then a clean read.
    setup(1, 8'h00, 1, 8'hFE, 0, 1'b0);
    start_read(16'h1000, 32'h0000_0010);
    for (int n = 0; n < 5000 && widx < 100; n++) @(negedge clock);
    check("reached_data_phase", 32'(widx >= 100), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_ctrl", 32'({busy, done, err, spi_sent, spi_cmd, mem_req}), 32'd0);
    check("midreset_data", {spi_out, mem_a, mem_d}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    setup(1, 8'h00, 1, 8'hFE, 0, 1'b0);
    start_read(16'h1000, 32'h0000_0010);
    wait_done(got);
    expect_end("after_reset", got, 3'd0, 512);
    check("ram_11ff", 32'(ram[16'h11FF]), 32'hFF);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_sector_reader.md
# sd_sector_reader

Hardware sequencer that reads one 512-byte SD-card sector over the byte-level `sdcard` SPI controller and writes it into the 64K RAM without CPU involvement. It sits beside the CPU I/O router in the top level. It drives the `sdcard` command interface in place of the port-0x23/0x24 writes. It shares the RAM write port with the CPU via a request/grant pair.

## Interface
Parameters:
- `R1_TRIES`, 8: maximum 0xFF polls while waiting for the R1 response.
- `TOKEN_TRIES`, 4096: maximum polls while waiting for the data token.

Ports (one clock; reset is asynchronous and active-low):
- `clock` in 1: system clock (25 MHz domain).
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins a read. Ignored while `busy`.
- `lba` in 32: sector address, sampled on `start`.
- `base` in 16: RAM destination, sampled on `start`.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse at completion (success or error).
- `err` out 3: result code, valid from `done` until the next `start`.
- `spi_sent` out 1: one-cycle command strobe to `sdcard`.
- `spi_cmd` out 2: command code.
- `spi_out` out 8: byte to transmit.
- `spi_din` in 8: last received byte.
- `spi_st` in 2: bit 1 = SPI busy, bit 0 = timeout.
- `mem_req` out 1: RAM write request.
- `mem_a` out 16: RAM write address.
- `mem_d` out 8: RAM write data.
- `mem_gnt` in 1: grant. A write completes in the cycle where `mem_req` and `mem_gnt` are both high.

## Operation
- SPI op handshake:
  - Assert `spi_sent` for 1 cycle with `spi_cmd`/`spi_out` valid.
  - Ignore `spi_st[1]` on the next cycle.
  - Then wait for `spi_st[1]==0`. `spi_din` is valid in that cycle.
  - If `spi_st[0]==1` at completion: `err=1`, go to DESEL.
- Command codes: 0 = init, 1 = transfer byte, 2 = CS low, 3 = CS high.
- State machine:
  - IDLE: wait for `start`, then go to SEL.
  - SEL: issue CS low.
  - CMD: transfer 6 bytes: 0x51, `lba[31:24]`, `lba[23:16]`, `lba[15:8]`, `lba[7:0]`, 0xFF.
  - R1: transfer 0xFF up to `R1_TRIES` times until `spi_din != 0xFF`.
    - Exhausted: `err=2`.
    - Response nonzero: `err=3`.
    - Response 0x00: go to TOK.
  - TOK: transfer 0xFF up to `TOKEN_TRIES` times.
    - 0xFE: go to DATA.
    - Byte with `[7:4]==0`: `err=5`.
    - Exhausted: `err=4`.
  - DATA: transfer 0xFF, then go to WR.
  - WR: hold `mem_req=1`, `mem_a=base+i`, `mem_d=spi_din` until `mem_gnt`. Then `i++`.
    - If `i==512`: go to CRC.
    - Otherwise: go to DATA.
  - CRC: transfer 0xFF twice; received bytes are discarded.
  - DESEL: issue CS high, then one 0xFF transfer (8 trailing clocks).
  - FIN: pulse `done`, go to IDLE.
- Every error path passes through DESEL so the card is always deselected. An SPI timeout inside DESEL is ignored and the first `err` is kept.
- `err` on success = 0.
- Byte counter `i` is 10 bits. `mem_a = base + i[8:0]`, 16-bit addition that wraps modulo 65536.

## Timing
- Reset: state IDLE. All outputs 0: `busy`, `done`, `err`, `spi_sent`, `spi_cmd`, `spi_out`, `mem_req`, `mem_a`, `mem_d`.
- `start` sampled in IDLE. First `spi_sent` (CS low) occurs the next cycle.
- At most one `spi_sent` is in flight. No new strobe is issued until the prior op completes.
- WR completes in the grant cycle. The next DATA strobe is issued the following cycle, so the minimum per-byte cost is SPI byte time + 3 cycles.
- `mem_req` is never high while an SPI op is in flight.
- `done` is high exactly 1 cycle. `busy` falls in the same cycle.
- `start` coincident with `done` is ignored.
- Reset mid-operation: outputs clear immediately. The card's CS is left to `sdcard`'s own reset; software re-inits the card.

## Structure
- Shared package `sd_pkg`:
  - SPI command codes.
  - CMD17 opcode 0x51.
  - Token 0xFE.
  - Error codes 0–5.
  - Sector size 512.
- One sub-module `sd_spi_op`: issues a single SPI op and waits for it. Outputs: `op_done` pulse, `op_timeout`, `op_rx`. The main FSM uses it for every transfer.

## Test plan
- Card model returns R1=0x00 on 2nd poll, token 0xFE on 5th, data `byte[i]=i[7:0]`, `base=0x8000`, `lba=0x00000123` → CMD bytes 51 00 00 01 23 FF; RAM 0x8000..0x81FF = 00..FF,00..FF; `done` with `err=0`.
- R1 stays 0xFF → exactly 8 polls, CS high issued, `err=2`.
- R1=0x04 → `err=3`. Token 0x05 → `err=5`. Token never arrives → 4096 polls, `err=4`.
- `mem_gnt` held low 10 cycles on byte 7 → `mem_req`/`mem_a`/`mem_d` stable throughout, no SPI strobe, data correct; `base=0xFF00` → bytes land in 0xFF00..0xFFFF then wrap to 0x0000..0x00FF.
- `spi_st[0]` asserted during CMD byte 3 → CS high, `err=1`. `reset_n` low mid-DATA → all outputs 0 next edge, later `start` completes normally.
